// File: rtl/stdp_pkg.sv
// Shared types and default constants for the pair-based STDP controller.
package stdp_pkg;

    localparam int STDP_W_WIDTH = 8;
    localparam int STDP_T_WIDTH = 4;
    localparam int STDP_WINDOW  = 8;
    localparam int STDP_W_INIT  = 64;
    localparam int STDP_A_PLUS  = 16;
    localparam int STDP_A_MINUS = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRE_OPEN  = 2'd1,
        POST_OPEN = 2'd2,
        UPDATE    = 2'd3
    } stdp_state_t;

endpackage

// File: rtl/stdp_weight_sat.sv
// Combinational STDP weight step: amplitude >> timer, then saturating add or subtract.
module stdp_weight_sat #(
    parameter int W_WIDTH = 8,
    parameter int T_WIDTH = 4
) (
    input  logic [W_WIDTH-1:0] weight,
    input  logic [T_WIDTH-1:0] shamt,
    input  logic               sign,
    input  logic [W_WIDTH-1:0] amp,
    output logic [W_WIDTH-1:0] weight_next
);

    logic [W_WIDTH-1:0] delta_s;
    logic [W_WIDTH:0]   sum_s;
    logic [W_WIDTH:0]   diff_s;

    // Decay the amplitude with dt and clamp the result into [0, 2^W_WIDTH-1].
    always_comb begin
        delta_s     = '0;
        sum_s       = '0;
        diff_s      = '0;
        weight_next = weight;
        if (32'(shamt) >= W_WIDTH) begin
            delta_s = '0;
        end else begin
            delta_s = amp >> shamt;
        end
        sum_s  = {1'b0, weight} + {1'b0, delta_s};
        diff_s = {1'b0, weight} - {1'b0, delta_s};
        if (sign) begin
            weight_next = sum_s[W_WIDTH] ? '1 : sum_s[W_WIDTH-1:0];
        end else begin
            // A borrow out of the top bit means the subtraction went below zero.
            weight_next = diff_s[W_WIDTH] ? '0 : diff_s[W_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/stdp_pair_ctrl.sv
// Nearest-neighbour pair STDP controller: interval timer, pairing FSM and weight register.
// Depression (POST_OPEN / A_MINUS) is built only when STDP_LTD_EN is defined.
module stdp_pair_ctrl
    import stdp_pkg::*;
#(
    parameter int W_WIDTH = STDP_W_WIDTH,
    parameter int T_WIDTH = STDP_T_WIDTH,
    parameter int WINDOW  = STDP_WINDOW,
    parameter int W_INIT  = STDP_W_INIT,
    parameter int A_PLUS  = STDP_A_PLUS,
    parameter int A_MINUS = STDP_A_MINUS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               learn_en,
    input  logic               pre_spike,
    input  logic               post_spike,
    output logic [W_WIDTH-1:0] weight,
    output logic [W_WIDTH-1:0] syn_current,
    output logic               w_upd,
    output logic               ltp
);

    localparam logic [T_WIDTH-1:0] T_ONE     = T_WIDTH'(1);
    localparam logic [T_WIDTH-1:0] T_LAST    = T_WIDTH'(WINDOW - 1);
    localparam logic [W_WIDTH-1:0] W_RESET   = W_WIDTH'(W_INIT);
    localparam logic [W_WIDTH-1:0] AMP_PLUS  = W_WIDTH'(A_PLUS);

    if (WINDOW < 1 || (WINDOW - 1) >= (2 ** T_WIDTH) ||
        A_PLUS >= (2 ** W_WIDTH) || A_MINUS >= (2 ** W_WIDTH)) begin : g_bad_params
        $error("stdp_pair_ctrl: parameters out of range");
    end

    stdp_state_t        state_r;
    logic [T_WIDTH-1:0] timer_r;
    logic [T_WIDTH-1:0] t_cap_r;
    logic [W_WIDTH-1:0] weight_r;
    logic [W_WIDTH-1:0] syn_current_r;
    logic               w_upd_r;
    logic [W_WIDTH-1:0] amp_s;
    logic               sign_s;
    logic [W_WIDTH-1:0] weight_next_s;

`ifdef STDP_LTD_EN
    localparam logic [W_WIDTH-1:0] AMP_MINUS = W_WIDTH'(A_MINUS);
    logic sign_r;
    logic ltp_r;
    assign sign_s = sign_r;
    assign amp_s  = sign_r ? AMP_PLUS : AMP_MINUS;
    assign ltp    = ltp_r;
`else
    assign sign_s = 1'b1;
    assign amp_s  = AMP_PLUS;
    assign ltp    = 1'b1;
`endif

    stdp_weight_sat #(
        .W_WIDTH (W_WIDTH),
        .T_WIDTH (T_WIDTH)
    ) u_weight_sat (
        .weight      (weight_r),
        .shamt       (t_cap_r),
        .sign        (sign_s),
        .amp         (amp_s),
        .weight_next (weight_next_s)
    );

    // Pairing FSM, interval timer, weight register and synaptic current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            timer_r       <= '0;
            t_cap_r       <= '0;
            weight_r      <= W_RESET;
            syn_current_r <= '0;
            w_upd_r       <= 1'b0;
`ifdef STDP_LTD_EN
            sign_r        <= 1'b0;
            ltp_r         <= 1'b0;
`endif
        end else begin
            syn_current_r <= pre_spike ? weight_r : '0;
            w_upd_r       <= 1'b0;
            if (!learn_en) begin
                state_r <= IDLE;
                timer_r <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        timer_r <= '0;
                        if (pre_spike && !post_spike) begin
                            state_r <= PRE_OPEN;
`ifdef STDP_LTD_EN
                        end else if (post_spike && !pre_spike) begin
                            state_r <= POST_OPEN;
`endif
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    PRE_OPEN: begin
                        // A coincident pre is dropped in favour of completing the pair.
                        if (post_spike) begin
                            t_cap_r <= timer_r;
`ifdef STDP_LTD_EN
                            sign_r  <= 1'b1;
`endif
                            state_r <= UPDATE;
                        end else if (pre_spike) begin
                            timer_r <= '0;
                        end else if (timer_r == T_LAST) begin
                            timer_r <= '0;
                            state_r <= IDLE;
                        end else begin
                            timer_r <= timer_r + T_ONE;
                        end
                    end
`ifdef STDP_LTD_EN
                    POST_OPEN: begin
                        if (pre_spike) begin
                            t_cap_r <= timer_r;
                            sign_r  <= 1'b0;
                            state_r <= UPDATE;
                        end else if (post_spike) begin
                            timer_r <= '0;
                        end else if (timer_r == T_LAST) begin
                            timer_r <= '0;
                            state_r <= IDLE;
                        end else begin
                            timer_r <= timer_r + T_ONE;
                        end
                    end
`endif
                    UPDATE: begin
                        weight_r <= weight_next_s;
                        w_upd_r  <= 1'b1;
`ifdef STDP_LTD_EN
                        ltp_r    <= sign_r;
`endif
                        timer_r  <= '0;
                        state_r  <= IDLE;
                    end
                    default: begin
                        timer_r <= '0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign weight      = weight_r;
    assign syn_current = syn_current_r;
    assign w_upd       = w_upd_r;

endmodule

// File: tb/tb_stdp_pair_ctrl.sv
// Directed self-checking bench for stdp_pair_ctrl; expectations adapt to STDP_LTD_EN.
module tb_stdp_pair_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       learn_en = 1'b1;
    logic       pre_spike = 1'b0;
    logic       post_spike = 1'b0;
    logic [7:0] weight;
    logic [7:0] syn_current;
    logic       w_upd;
    logic       ltp;

    int checks = 0;
    int errors = 0;

`ifdef STDP_LTD_EN
    localparam logic [7:0] EXP_W_LTD1  = 8'd48;
    localparam logic       EXP_UPD_LTD = 1'b1;
    localparam logic       EXP_LTP_LTD = 1'b0;
    localparam logic       EXP_LTP_RST = 1'b0;
`else
    localparam logic [7:0] EXP_W_LTD1  = 8'd64;
    localparam logic       EXP_UPD_LTD = 1'b0;
    localparam logic       EXP_LTP_LTD = 1'b1;
    localparam logic       EXP_LTP_RST = 1'b1;
`endif

    stdp_pair_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .learn_en    (learn_en),
        .pre_spike   (pre_spike),
        .post_spike  (post_spike),
        .weight      (weight),
        .syn_current (syn_current),
        .w_upd       (w_upd),
        .ltp         (ltp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic spike(input logic p, input logic q);
        pre_spike  = p;
        post_spike = q;
        tick();
        pre_spike  = 1'b0;
        post_spike = 1'b0;
    endtask

    // First spike in cycle 0, second in cycle dt; returns in cycle dt+2 (new weight visible).
    task automatic run_pair(input logic first_pre, input int dt);
        spike(first_pre, !first_pre);
        idle(dt - 1);
        spike(!first_pre, first_pre);
        tick();
    endtask

    task automatic do_reset();
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        learn_en   = 1'b1;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (weight !== 8'd64) begin errors++; $display("FAIL reset_weight got %0d want 64", weight); end
        checks++; if (syn_current !== 8'd0) begin errors++; $display("FAIL reset_syn got %0d want 0", syn_current); end
        checks++; if (w_upd !== 1'b0) begin errors++; $display("FAIL reset_wupd got %b want 0", w_upd); end
        checks++; if (ltp !== EXP_LTP_RST) begin errors++; $display("FAIL reset_ltp got %b want %b", ltp, EXP_LTP_RST); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (w_upd !== 1'b0 || weight !== 8'd64) begin
                errors++;
                $display("FAIL reset_hold got w_upd=%b weight=%0d want 0/64", w_upd, weight);
            end
        end
    endtask

    task automatic test_ltp_dt2();
        do_reset();
        spike(1'b1, 1'b0);
        idle(1);
        spike(1'b0, 1'b1);
        checks++; if (w_upd !== 1'b0 || weight !== 8'd64) begin errors++; $display("FAIL ltp_dt2_update_cycle got w_upd=%b weight=%0d want 0/64", w_upd, weight); end
        tick();
        checks++; if (weight !== 8'd72) begin errors++; $display("FAIL ltp_dt2_weight got %0d want 72", weight); end
        checks++; if (w_upd !== 1'b1) begin errors++; $display("FAIL ltp_dt2_wupd got %b want 1", w_upd); end
        checks++; if (ltp !== 1'b1) begin errors++; $display("FAIL ltp_dt2_ltp got %b want 1", ltp); end
        tick();
        checks++; if (w_upd !== 1'b0 || weight !== 8'd72) begin errors++; $display("FAIL ltp_dt2_after got w_upd=%b weight=%0d want 0/72", w_upd, weight); end
        // Asynchronous reset between clock edges.
        rst_n = 1'b0;
        #1;
        checks++; if (weight !== 8'd64) begin errors++; $display("FAIL async_reset_weight got %0d want 64", weight); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ltd_dt1();
        do_reset();
        run_pair(1'b0, 1);
        checks++; if (weight !== EXP_W_LTD1) begin errors++; $display("FAIL ltd_dt1_weight got %0d want %0d", weight, EXP_W_LTD1); end
        checks++; if (w_upd !== EXP_UPD_LTD) begin errors++; $display("FAIL ltd_dt1_wupd got %b want %b", w_upd, EXP_UPD_LTD); end
        checks++; if (ltp !== EXP_LTP_LTD) begin errors++; $display("FAIL ltd_dt1_ltp got %b want %b", ltp, EXP_LTP_LTD); end
        idle(10);
    endtask

    task automatic test_window();
        do_reset();
        spike(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++; if (w_upd !== 1'b0) begin errors++; $display("FAIL window_open_wupd got %b want 0", w_upd); end
            tick();
        end
        spike(1'b0, 1'b1);
        checks++; if (w_upd !== 1'b0 || weight !== 8'd64) begin errors++; $display("FAIL window_closed got w_upd=%b weight=%0d want 0/64", w_upd, weight); end
        spike(1'b1, 1'b0);
        tick();
        checks++; if (weight !== EXP_W_LTD1 || w_upd !== EXP_UPD_LTD) begin errors++; $display("FAIL window_post_opens got weight=%0d w_upd=%b want %0d/%b", weight, w_upd, EXP_W_LTD1, EXP_UPD_LTD); end
        idle(10);
    endtask

    task automatic test_zero_delta();
        do_reset();
        run_pair(1'b1, 8);
        checks++; if (w_upd !== 1'b1 || weight !== 8'd64 || ltp !== 1'b1) begin errors++; $display("FAIL zero_delta got w_upd=%b weight=%0d ltp=%b want 1/64/1", w_upd, weight, ltp); end
    endtask

    task automatic test_sat_high();
        do_reset();
        for (int i = 0; i < 11; i++) run_pair(1'b1, 1);
        run_pair(1'b1, 2);
        run_pair(1'b1, 4);
        checks++; if (weight !== 8'd250) begin errors++; $display("FAIL sat_high_setup got %0d want 250", weight); end
        run_pair(1'b1, 1);
        checks++; if (weight !== 8'd255 || w_upd !== 1'b1) begin errors++; $display("FAIL sat_high_clamp got weight=%0d w_upd=%b want 255/1", weight, w_upd); end
        run_pair(1'b1, 1);
        checks++; if (weight !== 8'd255) begin errors++; $display("FAIL sat_high_hold got %0d want 255", weight); end
    endtask

`ifdef STDP_LTD_EN
    task automatic test_sat_low();
        do_reset();
        for (int i = 0; i < 3; i++) run_pair(1'b0, 1);
        run_pair(1'b0, 2);
        run_pair(1'b0, 4);
        run_pair(1'b0, 5);
        checks++; if (weight !== 8'd5) begin errors++; $display("FAIL sat_low_setup got %0d want 5", weight); end
        run_pair(1'b0, 1);
        checks++; if (weight !== 8'd0 || w_upd !== 1'b1 || ltp !== 1'b0) begin errors++; $display("FAIL sat_low_clamp got weight=%0d w_upd=%b ltp=%b want 0/1/0", weight, w_upd, ltp); end
    endtask
`endif

    task automatic test_simultaneous();
        do_reset();
        spike(1'b1, 1'b1);
        checks++; if (syn_current !== 8'd64) begin errors++; $display("FAIL simul_syn got %0d want 64", syn_current); end
        tick();
        checks++; if (syn_current !== 8'd0) begin errors++; $display("FAIL simul_syn_clear got %0d want 0", syn_current); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (w_upd !== 1'b0 || weight !== 8'd64) begin errors++; $display("FAIL simul_no_update got w_upd=%b weight=%0d want 0/64", w_upd, weight); end
        end
    endtask

    task automatic test_learn_off();
        do_reset();
        learn_en = 1'b0;
        spike(1'b1, 1'b0);
        checks++; if (syn_current !== 8'd64) begin errors++; $display("FAIL learn_off_syn got %0d want 64", syn_current); end
        spike(1'b0, 1'b1);
        checks++; if (syn_current !== 8'd0) begin errors++; $display("FAIL learn_off_syn_clear got %0d want 0", syn_current); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (w_upd !== 1'b0 || weight !== 8'd64) begin errors++; $display("FAIL learn_off_no_update got w_upd=%b weight=%0d want 0/64", w_upd, weight); end
            tick();
        end
        // Dropping learn_en in the middle of an open window abandons the pair.
        learn_en = 1'b1;
        spike(1'b1, 1'b0);
        learn_en = 1'b0;
        spike(1'b0, 1'b1);
        tick();
        checks++; if (w_upd !== 1'b0 || weight !== 8'd64) begin errors++; $display("FAIL learn_off_abandon got w_upd=%b weight=%0d want 0/64", w_upd, weight); end
        learn_en = 1'b1;
        idle(2);
    endtask

    task automatic test_back_to_back();
        do_reset();
        spike(1'b1, 1'b0);
        spike(1'b0, 1'b1);
        spike(1'b1, 1'b0);
        checks++; if (weight !== 8'd80 || w_upd !== 1'b1 || ltp !== 1'b1) begin errors++; $display("FAIL b2b_first got weight=%0d w_upd=%b ltp=%b want 80/1/1", weight, w_upd, ltp); end
        checks++; if (syn_current !== 8'd64) begin errors++; $display("FAIL b2b_syn_old_weight got %0d want 64", syn_current); end
        spike(1'b0, 1'b1);
        checks++; if (w_upd !== 1'b0) begin errors++; $display("FAIL b2b_update_pre_ignored got %b want 0", w_upd); end
        spike(1'b1, 1'b0);
        checks++; if (syn_current !== 8'd80) begin errors++; $display("FAIL b2b_syn_new_weight got %0d want 80", syn_current); end
        tick();
`ifdef STDP_LTD_EN
        checks++; if (weight !== 8'd64 || w_upd !== 1'b1 || ltp !== 1'b0) begin errors++; $display("FAIL b2b_second got weight=%0d w_upd=%b ltp=%b want 64/1/0", weight, w_upd, ltp); end
`else
        checks++; if (weight !== 8'd80 || w_upd !== 1'b0) begin errors++; $display("FAIL b2b_second got weight=%0d w_upd=%b want 80/0", weight, w_upd); end
`endif
        idle(10);
    endtask

    initial begin
        test_reset();
        test_ltp_dt2();
        test_ltd_dt1();
        test_window();
        test_zero_delta();
        test_sat_high();
`ifdef STDP_LTD_EN
        test_sat_low();
`endif
        test_simultaneous();
        test_learn_off();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
